// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage placed directly after the PC register. It fetches
// the word at the current PC over a req/ack instruction-memory handshake
// with variable latency. The word and its PC go to the ID stage through an
// internal IF/ID register. While a fetch is outstanding the unit asks the
// stall controller to freeze PC/IF. Stalls, flushes and misaligned PCs are
// absorbed without losing or duplicating instructions.
//
// Ports:
//   clk        - system clock, all state updates on posedge
//   rst        - asynchronous reset, active low
//   pc_i       - current PC from the PC stage
//   stall      - stall vector: bit0 PC, bit1 IF, bit2 ID (1 = stop)
//   flush      - CP0 redirect; kills the IF/ID contents
//   stallreq_o - request to freeze PC/IF while a fetch is outstanding
//   imem_req   - instruction-memory request valid
//   imem_addr  - instruction-memory word address
//   imem_ack   - memory response valid (may coincide with imem_req)
//   imem_rdata - instruction word, valid with imem_ack
//   id_pc      - IF/ID register: PC of the instruction in ID
//   id_inst    - IF/ID register: instruction in ID
//   id_adel    - IF/ID register: fetch address-error flag
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'hBFC00000,
   parameter logic [31:0] NOP_INST   = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic [5:0]  stall,
   input  logic        flush,
   output logic        stallreq_o,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_adel
);

   localparam logic [1:0] S_FETCH   = 2'd0;
   localparam logic [1:0] S_HOLD    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]  state;
   logic [31:0] req_addr;
   logic [31:0] hold_pc;
   logic [31:0] hold_inst;
   logic        hold_adel;

   logic        misaligned;
   logic        fetch_done;
   logic [31:0] fetch_data;
   logic        hold_id;
   logic        unused_stall;

   assign misaligned   = (pc_i[1:0] != 2'b00);
   // A misaligned PC completes at once with a bubble word and the error flag.
   assign fetch_done   = (state == S_FETCH) && (misaligned || imem_ack);
   assign fetch_data   = misaligned ? NOP_INST : imem_rdata;
   assign hold_id      = stall[1] && stall[2];
   assign unused_stall = ^{stall[5:3], stall[0]};

   // Memory request and stall request. Nothing is requested while reset is
   // held. In DISCARD the latched address is replayed so the handshake stays
   // stable even though the PC has already been redirected.
   always_comb begin
      imem_req   = 1'b0;
      imem_addr  = req_addr;
      stallreq_o = 1'b0;
      if (rst) begin
         case (state)
            S_FETCH: begin
               if (!misaligned) begin
                  imem_req   = 1'b1;
                  imem_addr  = pc_i;
                  stallreq_o = ~imem_ack;
               end
            end
            S_DISCARD: begin
               imem_req   = 1'b1;
               imem_addr  = req_addr;
               stallreq_o = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // State, request latch, hold buffer and IF/ID register. Flush has the
   // highest priority. Otherwise ID gets a bubble unless IF and ID are both
   // stalled, and a real load later in the block overrides that bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_FETCH;
         req_addr  <= RESET_ADDR;
         hold_pc   <= 32'h0;
         hold_inst <= 32'h0;
         hold_adel <= 1'b0;
         id_pc     <= 32'h0;
         id_inst   <= NOP_INST;
         id_adel   <= 1'b0;
      end else begin
         if (state == S_FETCH && !misaligned) begin
            req_addr <= pc_i;
         end
         if (flush) begin
            id_pc   <= 32'h0;
            id_inst <= NOP_INST;
            id_adel <= 1'b0;
            case (state)
               S_FETCH:   state <= (!misaligned && !imem_ack) ? S_DISCARD : S_FETCH;
               S_DISCARD: state <= imem_ack ? S_FETCH : S_DISCARD;
               default:   state <= S_FETCH;
            endcase
         end else begin
            if (!hold_id) begin
               id_pc   <= 32'h0;
               id_inst <= NOP_INST;
               id_adel <= 1'b0;
            end
            case (state)
               S_FETCH: begin
                  if (fetch_done) begin
                     if (!stall[1]) begin
                        id_pc   <= pc_i;
                        id_inst <= fetch_data;
                        id_adel <= misaligned;
                     end else begin
                        hold_pc   <= pc_i;
                        hold_inst <= fetch_data;
                        hold_adel <= misaligned;
                        state     <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  if (!stall[1]) begin
                     id_pc   <= hold_pc;
                     id_inst <= hold_inst;
                     id_adel <= hold_adel;
                     state   <= S_FETCH;
                  end
               end
               S_DISCARD: begin
                  if (imem_ack) begin
                     state <= S_FETCH;
                  end
               end
               default: state <= S_FETCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed testbench for if_fetch_unit. It covers reset, zero-wait fetch,
// a multi-cycle fetch, a stalled completion through HOLD, a flush during an
// outstanding fetch, a misaligned PC, and reset asserted mid-fetch.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic [5:0]  stall;
   logic        flush;
   logic        stallreq_o;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_adel;

   logic        tie_ack;
   logic        ack_manual;
   logic [31:0] rdata_manual;

   int compared;
   int mismatched;

   if_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .pc_i       (pc_i),
      .stall      (stall),
      .flush      (flush),
      .stallreq_o (stallreq_o),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_pc      (id_pc),
      .id_inst    (id_inst),
      .id_adel    (id_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait memory model: ack mirrors req and data is addr ^ 0xFFFF0000.
   // In manual mode the directed steps drive ack and data themselves.
   always_comb begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      if (tie_ack) begin
         imem_ack   = imem_req;
         imem_rdata = imem_addr ^ 32'hFFFF0000;
      end else begin
         imem_ack   = ack_manual;
         imem_rdata = rdata_manual;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] pc, input logic [5:0] stl,
                                 input logic fl, input logic ack,
                                 input logic [31:0] rdata);
      pc_i         = pc;
      stall        = stl;
      flush        = fl;
      ack_manual   = ack;
      rdata_manual = rdata;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst          = 1'b0;
      tie_ack      = 1'b1;
      pc_i         = 32'hBFC00000;
      stall        = 6'b0;
      flush        = 1'b0;
      ack_manual   = 1'b0;
      rdata_manual = 32'h0;

      // Reset values
      #2;
      check_output("rst_id_pc",    id_pc,      32'h0);
      check_output("rst_id_inst",  id_inst,    32'h0);
      check_output("rst_id_adel",  id_adel,    32'h0);
      check_output("rst_req",      imem_req,   32'h0);
      check_output("rst_stallreq", stallreq_o, 32'h0);

      // Zero-wait stream: ID follows PC with one cycle of lag
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("zw0_req",      imem_req,   32'h1);
      check_output("zw0_addr",     imem_addr,  32'hBFC00000);
      check_output("zw0_stallreq", stallreq_o, 32'h0);
      next_cycle();
      check_output("zw0_id_pc",    id_pc,      32'hBFC00000);
      check_output("zw0_id_inst",  id_inst,    32'h403F0000);
      apply_stimulus(32'hBFC00004, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("zw1_stallreq", stallreq_o, 32'h0);
      next_cycle();
      check_output("zw1_id_pc",    id_pc,      32'hBFC00004);
      check_output("zw1_id_inst",  id_inst,    32'h403F0004);
      apply_stimulus(32'hBFC00008, 6'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
      check_output("zw2_id_pc",    id_pc,      32'hBFC00008);
      check_output("zw2_id_inst",  id_inst,    32'h403F0008);

      // Three-cycle fetch: request held, stall requested, bubbles into ID
      tie_ack = 1'b0;
      apply_stimulus(32'hBFC00010, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("lat_c1_req",      imem_req,   32'h1);
      check_output("lat_c1_addr",     imem_addr,  32'hBFC00010);
      check_output("lat_c1_stallreq", stallreq_o, 32'h1);
      next_cycle();
      check_output("lat_c1_id_inst",  id_inst,    32'h0);
      check_output("lat_c1_id_pc",    id_pc,      32'h0);
      check_output("lat_c2_addr",     imem_addr,  32'hBFC00010);
      check_output("lat_c2_stallreq", stallreq_o, 32'h1);
      next_cycle();
      check_output("lat_c2_id_inst",  id_inst,    32'h0);
      apply_stimulus(32'hBFC00010, 6'b0, 1'b0, 1'b1, 32'h403F0010);
      check_output("lat_c3_req",      imem_req,   32'h1);
      check_output("lat_c3_stallreq", stallreq_o, 32'h0);
      next_cycle();
      check_output("lat_id_pc",       id_pc,      32'hBFC00010);
      check_output("lat_id_inst",     id_inst,    32'h403F0010);

      // Completion under IF+ID stall goes to HOLD; ID is held
      apply_stimulus(32'hBFC00014, 6'b000111, 1'b0, 1'b1, 32'h403F0014);
      next_cycle();
      check_output("hold_c1_id_pc",    id_pc,      32'hBFC00010);
      check_output("hold_c1_req",      imem_req,   32'h0);
      check_output("hold_c1_stallreq", stallreq_o, 32'h0);
      next_cycle();
      check_output("hold_c2_id_inst",  id_inst,    32'h403F0010);
      check_output("hold_c2_req",      imem_req,   32'h0);
      apply_stimulus(32'hBFC00014, 6'b0, 1'b0, 1'b1, 32'h11111111);
      check_output("hold_release_req", imem_req,   32'h0);
      next_cycle();
      check_output("hold_id_pc",       id_pc,      32'hBFC00014);
      check_output("hold_id_inst",     id_inst,    32'h403F0014);
      tie_ack = 1'b1;
      apply_stimulus(32'hBFC00018, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("after_hold_addr",  imem_addr,  32'hBFC00018);
      next_cycle();
      check_output("after_hold_id_pc", id_pc,      32'hBFC00018);

      // Flush in cycle 2 of a four-cycle fetch; stale data is discarded
      tie_ack = 1'b0;
      apply_stimulus(32'hBFC00020, 6'b000111, 1'b0, 1'b0, 32'h0);
      check_output("fl_c1_addr",      imem_addr,  32'hBFC00020);
      next_cycle();
      check_output("fl_c1_id_pc",     id_pc,      32'hBFC00018);
      apply_stimulus(32'hBFC00020, 6'b0, 1'b1, 1'b0, 32'h0);
      next_cycle();
      check_output("fl_id_pc_clr",    id_pc,      32'h0);
      check_output("fl_id_inst_clr",  id_inst,    32'h0);
      apply_stimulus(32'h80000180, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("fl_c3_req",       imem_req,   32'h1);
      check_output("fl_c3_addr",      imem_addr,  32'hBFC00020);
      check_output("fl_c3_stallreq",  stallreq_o, 32'h1);
      next_cycle();
      apply_stimulus(32'h80000180, 6'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      check_output("fl_c4_addr",      imem_addr,  32'hBFC00020);
      next_cycle();
      check_output("fl_stale_inst",   id_inst,    32'h0);
      check_output("fl_stale_pc",     id_pc,      32'h0);
      apply_stimulus(32'h80000180, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("fl_new_addr",     imem_addr,  32'h80000180);
      check_output("fl_new_req",      imem_req,   32'h1);
      apply_stimulus(32'h80000180, 6'b0, 1'b0, 1'b1, 32'h12345678);
      next_cycle();
      check_output("fl_new_id_pc",    id_pc,      32'h80000180);
      check_output("fl_new_id_inst",  id_inst,    32'h12345678);

      // Misaligned PC: no request, address-error bubble into ID
      apply_stimulus(32'hBFC00006, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("mis_req",      imem_req,   32'h0);
      check_output("mis_stallreq", stallreq_o, 32'h0);
      next_cycle();
      check_output("mis_id_pc",    id_pc,      32'hBFC00006);
      check_output("mis_id_inst",  id_inst,    32'h0);
      check_output("mis_id_adel",  id_adel,    32'h1);

      // Reset asserted during an outstanding fetch
      apply_stimulus(32'hBFC00040, 6'b0, 1'b0, 1'b0, 32'h0);
      check_output("mrst_req_before", imem_req,   32'h1);
      rst = 1'b0;
      #1;
      check_output("mrst_req",      imem_req,   32'h0);
      check_output("mrst_stallreq", stallreq_o, 32'h0);
      check_output("mrst_id_pc",    id_pc,      32'h0);
      check_output("mrst_id_adel",  id_adel,    32'h0);
      pc_i = 32'hBFC00080;
      rst  = 1'b1;
      #1;
      check_output("mrst_new_req",  imem_req,   32'h1);
      check_output("mrst_new_addr", imem_addr,  32'hBFC00080);
      apply_stimulus(32'hBFC00080, 6'b0, 1'b0, 1'b1, 32'hCAFEF00D);
      next_cycle();
      check_output("mrst_id_pc",    id_pc,      32'hBFC00080);
      check_output("mrst_id_inst",  id_inst,    32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
